mem_port_arbiter: RTL

- Arbitrates one single-ported instruction/data memory between the IF stage (instruction fetch, read-only) and the MEM stage (lw/sw).
- Sequences each access over a ready-handshake memory bus and returns the data to the granted stage.
- Generates per-stage stall signals that feed the Hazard_detection_unit PCWrite/IFIDWrite/freeze logic.
- Includes IF anti-starvation and a bus timeout guard.

---
 rtl/mem_port_arbiter_if.sv | 46 ++++
 rtl/mem_port_arbiter.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter_if.sv
// Bundle of the pipeline-side request/response ports and the memory bus
// around mem_port_arbiter. The master modport is the arbiter's view.
interface mem_port_arbiter_if;
    logic        IF_Req;
    logic [31:0] IF_Addr;
    logic [31:0] IF_RData;
    logic        IF_Valid;
    logic        IF_Stall;

    logic        MEM_Req;
    logic        MEM_Write;
    logic [31:0] MEM_Addr;
    logic [31:0] MEM_WData;
    logic [31:0] MEM_RData;
    logic        MEM_Valid;
    logic        MEM_Stall;

    logic        Mem_Req;
    logic        Mem_Write;
    logic [31:0] Mem_Addr;
    logic [31:0] Mem_WData;
    logic        Mem_Ready;
    logic [31:0] Mem_RData;

    logic        Timeout;

    modport master (
        input  IF_Req, IF_Addr,
        output IF_RData, IF_Valid, IF_Stall,
        input  MEM_Req, MEM_Write, MEM_Addr, MEM_WData,
        output MEM_RData, MEM_Valid, MEM_Stall,
        output Mem_Req, Mem_Write, Mem_Addr, Mem_WData,
        input  Mem_Ready, Mem_RData,
        output Timeout
    );

    modport slave (
        output IF_Req, IF_Addr,
        input  IF_RData, IF_Valid, IF_Stall,
        output MEM_Req, MEM_Write, MEM_Addr, MEM_WData,
        input  MEM_RData, MEM_Valid, MEM_Stall,
        input  Mem_Req, Mem_Write, Mem_Addr, Mem_WData,
        output Mem_Ready, Mem_RData,
        input  Timeout
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one single-ported memory between instruction fetch and the MEM stage,
// with IF anti-starvation and a bus timeout guard.
//
// state  | meaning
// IDLE   | no access in flight; grant decision made here
// ACCESS | Mem_Req asserted, waiting for Mem_Ready or timeout
// RESP   | owner's Valid pulses for one cycle, no grant
module mem_port_arbiter #(
    parameter int STARVE_LIM  = 4,
    parameter int TIMEOUT_CYC = 16
) (
    input  logic               CLK,
    input  logic               RESET,
    mem_port_arbiter_if.master bus
);
    localparam int SW = (STARVE_LIM < 1) ? 1 : $clog2(STARVE_LIM + 1);
    localparam int TW = (TIMEOUT_CYC < 2) ? 1 : $clog2(TIMEOUT_CYC);
    localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIM);
    localparam logic [TW-1:0] TO_LAST = TW'((TIMEOUT_CYC > 0) ? TIMEOUT_CYC - 1 : 0);
    localparam bit TO_EN = (TIMEOUT_CYC > 0);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    state_t state_q, state_d;

    logic          grant_if, grant_mem, done, abort;
    logic          owner_q, owner_d;   // 1 = MEM stage owns the access
    logic [SW-1:0] starve_q, starve_d;
    logic [TW-1:0] to_q, to_d;
    logic          mem_req_q, mem_req_d;
    logic          mem_write_q, mem_write_d;
    logic [31:0]   mem_addr_q, mem_addr_d;
    logic [31:0]   mem_wdata_q, mem_wdata_d;
    logic [31:0]   if_rdata_q, if_rdata_d;
    logic          if_valid_q, if_valid_d;
    logic [31:0]   mem_rdata_q, mem_rdata_d;
    logic          mem_valid_q, mem_valid_d;
    logic          timeout_q, timeout_d;
    logic [31:0]   rsp_data;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        grant_if  = 1'b0;
        grant_mem = 1'b0;
        done      = 1'b0;
        abort     = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.MEM_Req && bus.IF_Req && (starve_q == STARVE_MAX)) begin
                    grant_if = 1'b1;
                end else if (bus.MEM_Req) begin
                    grant_mem = 1'b1;
                end else if (bus.IF_Req) begin
                    grant_if = 1'b1;
                end
                if (grant_if || grant_mem) begin
                    state_d = ACCESS;
                end
            end
            ACCESS: begin
                // Ready beats a timeout landing in the same cycle.
                if (bus.Mem_Ready) begin
                    done = 1'b1;
                end else if (TO_EN && (to_q == TO_LAST)) begin
                    abort = 1'b1;
                end
                if (done || abort) begin
                    state_d = RESP;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign rsp_data = done ? bus.Mem_RData : 32'h0000_0000;

    always_comb begin
        owner_d     = owner_q;
        starve_d    = starve_q;
        to_d        = to_q;
        mem_req_d   = mem_req_q;
        mem_write_d = mem_write_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        if_rdata_d  = if_rdata_q;
        if_valid_d  = 1'b0;
        mem_rdata_d = mem_rdata_q;
        mem_valid_d = 1'b0;
        timeout_d   = timeout_q;

        if (grant_mem) begin
            owner_d     = 1'b1;
            mem_req_d   = 1'b1;
            mem_write_d = bus.MEM_Write;
            mem_addr_d  = bus.MEM_Addr;
            mem_wdata_d = bus.MEM_WData;
            to_d        = '0;
            if (bus.IF_Req) begin
                starve_d = (starve_q == STARVE_MAX) ? starve_q : starve_q + 1'b1;
            end else begin
                starve_d = '0;
            end
        end else if (grant_if) begin
            owner_d     = 1'b0;
            mem_req_d   = 1'b1;
            mem_write_d = 1'b0;
            mem_addr_d  = bus.IF_Addr;
            mem_wdata_d = 32'h0000_0000;
            to_d        = '0;
            starve_d    = '0;
        end

        if (state_q == ACCESS) begin
            if (done || abort) begin
                mem_req_d = 1'b0;
                if (owner_q) begin
                    mem_valid_d = 1'b1;
                    // A completed store leaves the load data register alone.
                    if (abort || !mem_write_q) begin
                        mem_rdata_d = rsp_data;
                    end
                end else begin
                    if_valid_d = 1'b1;
                    if_rdata_d = rsp_data;
                end
                if (abort) begin
                    timeout_d = 1'b1;
                end
            end else begin
                to_d = TO_EN ? to_q + 1'b1 : '0;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            owner_q     <= 1'b0;
            starve_q    <= '0;
            to_q        <= '0;
            mem_req_q   <= 1'b0;
            mem_write_q <= 1'b0;
            mem_addr_q  <= 32'h0000_0000;
            mem_wdata_q <= 32'h0000_0000;
            if_rdata_q  <= 32'h0000_0000;
            if_valid_q  <= 1'b0;
            mem_rdata_q <= 32'h0000_0000;
            mem_valid_q <= 1'b0;
            timeout_q   <= 1'b0;
        end else begin
            owner_q     <= owner_d;
            starve_q    <= starve_d;
            to_q        <= to_d;
            mem_req_q   <= mem_req_d;
            mem_write_q <= mem_write_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            if_rdata_q  <= if_rdata_d;
            if_valid_q  <= if_valid_d;
            mem_rdata_q <= mem_rdata_d;
            mem_valid_q <= mem_valid_d;
            timeout_q   <= timeout_d;
        end
    end

    assign bus.Mem_Req   = mem_req_q;
    assign bus.Mem_Write = mem_write_q;
    assign bus.Mem_Addr  = mem_addr_q;
    assign bus.Mem_WData = mem_wdata_q;
    assign bus.IF_RData  = if_rdata_q;
    assign bus.IF_Valid  = if_valid_q;
    assign bus.MEM_RData = mem_rdata_q;
    assign bus.MEM_Valid = mem_valid_q;
    assign bus.Timeout   = timeout_q;

    // Stalls see the registered Valid so a stage releases in its Valid cycle.
    assign bus.IF_Stall  = bus.IF_Req & ~if_valid_q;
    assign bus.MEM_Stall = bus.MEM_Req & ~mem_valid_q;
endmodule
